// File: rtl/cci_test_csr_mgr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cci_test_csr_mgr_pkg
// Brief    : Shared types, constants and address decode for the test CSR block
// Revision : 1.0 - initial release
// ============================================================================
package cci_test_csr_mgr_pkg;

    localparam int NUM_TEST_CSRS = 16;
    localparam int c_csr_idx_w   = $clog2(NUM_TEST_CSRS);

    localparam logic [63:0] c_dfh_value      = 64'h1000_0100_0000_0000;
    localparam logic [15:0] c_dfh_waddr      = 16'h0000;
    localparam logic [15:0] c_afu_id_l_waddr = 16'h0002;
    localparam logic [15:0] c_afu_id_h_waddr = 16'h0004;
    localparam logic [15:0] c_rsvd0_waddr    = 16'h0006;
    localparam logic [15:0] c_rsvd1_waddr    = 16'h0008;

    typedef struct packed {
        logic        valid;
        logic [8:0]  tid;
        logic [63:0] data;
    } t_mmio_rsp;

    typedef struct packed {
        logic        en;
        logic [63:0] data;
    } t_cpu_wr_csr;

    typedef struct packed {
        logic                   hit;
        logic [c_csr_idx_w-1:0] idx;
    } t_csr_sel;

    // Test CSRs sit on even word addresses starting at the base.
    function automatic t_csr_sel csr_decode(input logic [15:0] waddr,
                                            input logic [15:0] base_waddr,
                                            input int          num_csrs);
        logic [15:0] offset;
        t_csr_sel    sel;
        offset  = waddr - base_waddr;
        sel.hit = (waddr >= base_waddr) && !offset[0] &&
                  ({1'b0, offset[15:1]} < 16'(num_csrs));
        sel.idx = offset[c_csr_idx_w:1];
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/test_csrs.sv
`default_nettype none
// ============================================================================
// Module   : test_csrs
// Brief    : Test CSR interface between the MMIO manager and the AFU test logic
// Revision : 1.0 - initial release
// ============================================================================
interface test_csrs;
    import cci_test_csr_mgr_pkg::*;

    logic [127:0]                        afu_id;
    logic [NUM_TEST_CSRS-1:0][63:0]      cpu_rd_csrs;
    t_cpu_wr_csr [NUM_TEST_CSRS-1:0]     cpu_wr_csrs;

    modport csr  (input afu_id, input cpu_rd_csrs, output cpu_wr_csrs);
    modport test (output afu_id, output cpu_rd_csrs, input cpu_wr_csrs);
endinterface
`default_nettype wire

// File: rtl/cci_test_csr_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cci_test_csr_rd_pipe
// Brief    : Two-stage MMIO read pipeline: request reg, decode/mux, response reg
// Revision : 1.0 - initial release
// ============================================================================
module cci_test_csr_rd_pipe
    import cci_test_csr_mgr_pkg::*;
#(
    parameter logic [15:0] CSR_BASE_WADDR = 16'h0020,
    parameter int          NUM_CSRS       = NUM_TEST_CSRS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rd_valid,
    input  logic [15:0]                   rd_addr,
    input  logic [8:0]                    rd_tid,
    input  logic [127:0]                  afu_id,
    input  logic [NUM_TEST_CSRS-1:0][63:0] cpu_rd_csrs,
    output logic                          rsp_valid,
    output logic [8:0]                    rsp_tid,
    output logic [63:0]                   rsp_data
);

    logic        r_req_valid;
    logic [15:0] r_req_addr;
    logic [8:0]  r_req_tid;
    t_csr_sel    w_sel;
    logic [63:0] w_rd_data;
    t_mmio_rsp   r_rsp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_tid   <= '0;
        end else begin
            r_req_valid <= rd_valid;
            r_req_addr  <= rd_addr;
            r_req_tid   <= rd_tid;
        end
    end

    always_comb begin
        w_sel     = csr_decode(r_req_addr, CSR_BASE_WADDR, NUM_CSRS);
        w_rd_data = '0;
        case (r_req_addr)
            c_dfh_waddr:                   w_rd_data = c_dfh_value;
            c_afu_id_l_waddr:              w_rd_data = afu_id[63:0];
            c_afu_id_h_waddr:              w_rd_data = afu_id[127:64];
            c_rsvd0_waddr, c_rsvd1_waddr:  w_rd_data = '0;
            default: begin
                if (w_sel.hit) begin
                    w_rd_data = cpu_rd_csrs[w_sel.idx];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp <= '0;
        end else begin
            r_rsp.valid <= r_req_valid;
            r_rsp.tid   <= r_req_tid;
            r_rsp.data  <= w_rd_data;
        end
    end

    // Outputs read as zero for the whole time reset is held, including its first cycle.
    assign rsp_valid = r_rsp.valid & ~reset;
    assign rsp_tid   = reset ? '0 : r_rsp.tid;
    assign rsp_data  = reset ? '0 : r_rsp.data;

endmodule
`default_nettype wire

// File: rtl/cci_test_csr_mgr.sv
`default_nettype none
// ============================================================================
// Module   : cci_test_csr_mgr
// Brief    : MMIO manager for the AFU header and the bank of test CSRs
// Revision : 1.0 - initial release
// ============================================================================
module cci_test_csr_mgr
    import cci_test_csr_mgr_pkg::*;
#(
    parameter logic [15:0] CSR_BASE_WADDR = 16'h0020,
    parameter int          NUM_TEST_CSRS  = cci_test_csr_mgr_pkg::NUM_TEST_CSRS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mmio_wr_valid,
    input  logic [15:0] mmio_wr_addr,
    input  logic        mmio_wr_len64,
    input  logic [63:0] mmio_wr_data,
    input  logic        mmio_rd_valid,
    input  logic [15:0] mmio_rd_addr,
    input  logic [8:0]  mmio_rd_tid,
    output logic        mmio_rsp_valid,
    output logic [8:0]  mmio_rsp_tid,
    output logic [63:0] mmio_rsp_data,
    test_csrs.csr       csrs
);

    t_csr_sel                          w_wr_sel;
    logic                              w_wr_hit;
    logic [NUM_TEST_CSRS-1:0]          r_wr_en;
    logic [NUM_TEST_CSRS-1:0][63:0]    r_wr_data;
    t_cpu_wr_csr [NUM_TEST_CSRS-1:0]   w_wr_csrs;

    cci_test_csr_rd_pipe #(
        .CSR_BASE_WADDR (CSR_BASE_WADDR),
        .NUM_CSRS       (NUM_TEST_CSRS)
    ) u_rd_pipe (
        .clk         (clk),
        .reset       (reset),
        .rd_valid    (mmio_rd_valid),
        .rd_addr     (mmio_rd_addr),
        .rd_tid      (mmio_rd_tid),
        .afu_id      (csrs.afu_id),
        .cpu_rd_csrs (csrs.cpu_rd_csrs),
        .rsp_valid   (mmio_rsp_valid),
        .rsp_tid     (mmio_rsp_tid),
        .rsp_data    (mmio_rsp_data)
    );

    always_comb begin
        w_wr_sel = csr_decode(mmio_wr_addr, CSR_BASE_WADDR, NUM_TEST_CSRS);
        w_wr_hit = mmio_wr_valid && mmio_wr_len64 && w_wr_sel.hit;
    end

    // A single decoded index per cycle keeps the enable vector one-hot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en   <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= '0;
            if (w_wr_hit) begin
                r_wr_en[w_wr_sel.idx]   <= 1'b1;
                r_wr_data[w_wr_sel.idx] <= mmio_wr_data;
            end
        end
    end

    always_comb begin
        w_wr_csrs = '0;
        for (int i = 0; i < NUM_TEST_CSRS; i++) begin
            w_wr_csrs[i].en   = r_wr_en[i] & ~reset;
            w_wr_csrs[i].data = reset ? 64'h0 : r_wr_data[i];
        end
    end

    assign csrs.cpu_wr_csrs = w_wr_csrs;

endmodule
`default_nettype wire

// File: tb/tb_cci_test_csr_mgr.sv
`default_nettype none
// ============================================================================
// Module   : tb_cci_test_csr_mgr
// Brief    : Directed self-checking bench with a read-response scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module tb_cci_test_csr_mgr;

    logic        clk = 1'b0;
    logic        reset;
    logic        mmio_wr_valid;
    logic [15:0] mmio_wr_addr;
    logic        mmio_wr_len64;
    logic [63:0] mmio_wr_data;
    logic        mmio_rd_valid;
    logic [15:0] mmio_rd_addr;
    logic [8:0]  mmio_rd_tid;
    logic        mmio_rsp_valid;
    logic [8:0]  mmio_rsp_tid;
    logic [63:0] mmio_rsp_data;

    logic [127:0]     tb_afu_id;
    logic [15:0][63:0] tb_rd_csrs;
    logic [15:0]       obs_en;
    logic [15:0][63:0] obs_wdata;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          cyc;
    } t_exp;

    t_exp sb[$];
    t_exp mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    test_csrs u_csrs();
    assign u_csrs.afu_id      = tb_afu_id;
    assign u_csrs.cpu_rd_csrs = tb_rd_csrs;

    cci_test_csr_mgr dut (
        .clk            (clk),
        .reset          (reset),
        .mmio_wr_valid  (mmio_wr_valid),
        .mmio_wr_addr   (mmio_wr_addr),
        .mmio_wr_len64  (mmio_wr_len64),
        .mmio_wr_data   (mmio_wr_data),
        .mmio_rd_valid  (mmio_rd_valid),
        .mmio_rd_addr   (mmio_rd_addr),
        .mmio_rd_tid    (mmio_rd_tid),
        .mmio_rsp_valid (mmio_rsp_valid),
        .mmio_rsp_tid   (mmio_rsp_tid),
        .mmio_rsp_data  (mmio_rsp_data),
        .csrs           (u_csrs)
    );

    always_comb begin
        obs_en    = '0;
        obs_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            obs_en[i]    = u_csrs.cpu_wr_csrs[i].en;
            obs_wdata[i] = u_csrs.cpu_wr_csrs[i].data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_rd(input logic [15:0] a);
        int idx;
        if (a == 16'h0000) return 64'h1000_0100_0000_0000;
        if (a == 16'h0002) return tb_afu_id[63:0];
        if (a == 16'h0004) return tb_afu_id[127:64];
        if (a >= 16'h0020 && a < 16'h0040 && a[0] == 1'b0) begin
            idx = (int'(a) - 32) / 2;
            return tb_rd_csrs[idx];
        end
        return 64'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [8:0] t, input bit expect_rsp);
        mmio_rd_valid = 1'b1;
        mmio_rd_addr  = a;
        mmio_rd_tid   = t;
        if (expect_rsp) sb.push_back('{tid: t, data: model_rd(a), cyc: cyc + 2});
        tick();
        mmio_rd_valid = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic l64, input logic [63:0] d);
        mmio_wr_valid = 1'b1;
        mmio_wr_addr  = a;
        mmio_wr_len64 = l64;
        mmio_wr_data  = d;
        tick();
        mmio_wr_valid = 1'b0;
    endtask

    // Every response must match the oldest outstanding read, exactly two cycles after issue.
    always @(negedge clk) begin
        if (mmio_rsp_valid !== 1'b0) begin
            chk("rsp_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("rsp_tid",     64'(mmio_rsp_tid), 64'(mon_e.tid));
                chk("rsp_data",    mmio_rsp_data,     mon_e.data);
                chk("rsp_latency", 64'(cyc),          64'(mon_e.cyc));
            end
        end
        chk("en_onehot", 64'($countones(obs_en) <= 1), 64'd1);
    end

    initial begin
        reset         = 1'b1;
        mmio_wr_valid = 1'b0;
        mmio_wr_addr  = '0;
        mmio_wr_len64 = 1'b0;
        mmio_wr_data  = '0;
        mmio_rd_valid = 1'b0;
        mmio_rd_addr  = '0;
        mmio_rd_tid   = '0;
        tb_afu_id     = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        for (int i = 0; i < 16; i++) begin
            tb_rd_csrs[i] = {32'hC5A0_0000 | 32'(i), ~(32'(i) * 32'h0101_0101)};
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 64'(mmio_rsp_valid), 64'd0);
        chk("rst_rsp_tid",   64'(mmio_rsp_tid),   64'd0);
        chk("rst_rsp_data",  mmio_rsp_data,       64'd0);
        chk("rst_en",        64'(obs_en),         64'd0);
        chk("rst_wdata",     64'(|obs_wdata),     64'd0);
        tick();
        reset = 1'b0;

        // Header, AFU id halves back-to-back, CSR bank and out-of-range addresses.
        rd(16'h0000, 9'h005, 1'b1);
        rd(16'h0002, 9'h010, 1'b1);
        rd(16'h0004, 9'h011, 1'b1);
        rd(16'h0026, 9'h020, 1'b1);
        rd(16'h003E, 9'h021, 1'b1);
        rd(16'h0020, 9'h022, 1'b1);
        rd(16'h0021, 9'h023, 1'b1);
        rd(16'h0040, 9'h024, 1'b1);
        rd(16'h0006, 9'h025, 1'b1);
        rd(16'h0008, 9'h026, 1'b1);
        rd(16'h001F, 9'h027, 1'b1);
        rd(16'h003F, 9'h028, 1'b1);
        repeat (3) tick();

        wr(16'h0026, 1'b1, 64'h0000_0000_DEAD_BEEF);
        @(negedge clk);
        chk("wr3_en",   64'(obs_en), 64'h0008);
        chk("wr3_data", obs_wdata[3], 64'h0000_0000_DEAD_BEEF);
        tick();
        @(negedge clk);
        chk("wr3_en_clear", 64'(obs_en), 64'h0000);
        chk("wr3_data_hold", obs_wdata[3], 64'h0000_0000_DEAD_BEEF);
        tick();

        wr(16'h0020, 1'b0, 64'h1111_2222_3333_4444);
        @(negedge clk);
        chk("wr32_no_en", 64'(obs_en), 64'h0000);
        chk("wr32_no_data", obs_wdata[0], 64'h0);
        tick();
        wr(16'h0100, 1'b1, 64'h5555_6666_7777_8888);
        @(negedge clk);
        chk("wr_far_no_en", 64'(obs_en), 64'h0000);
        tick();
        wr(16'h0040, 1'b1, 64'h1);
        @(negedge clk);
        chk("wr_above_no_en", 64'(obs_en), 64'h0000);
        tick();
        wr(16'h001E, 1'b1, 64'h2);
        @(negedge clk);
        chk("wr_below_no_en", 64'(obs_en), 64'h0000);
        tick();
        wr(16'h0021, 1'b1, 64'h3);
        @(negedge clk);
        chk("wr_odd_no_en", 64'(obs_en), 64'h0000);
        tick();
        wr(16'h003E, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0);
        @(negedge clk);
        chk("wr15_en",   64'(obs_en), 64'h8000);
        chk("wr15_data", obs_wdata[15], 64'hA5A5_5A5A_0F0F_F0F0);
        tick();

        // Same-cycle read and write of CSR 5; the read sees cpu_rd_csrs as of the next cycle.
        mmio_rd_valid = 1'b1;
        mmio_rd_addr  = 16'h002A;
        mmio_rd_tid   = 9'h033;
        mmio_wr_valid = 1'b1;
        mmio_wr_addr  = 16'h002A;
        mmio_wr_len64 = 1'b1;
        mmio_wr_data  = 64'h5555_0000_0000_5555;
        sb.push_back('{tid: 9'h033, data: 64'hFEED_FACE_0BAD_F00D, cyc: cyc + 2});
        tick();
        mmio_rd_valid = 1'b0;
        mmio_wr_valid = 1'b0;
        tb_rd_csrs[5] = 64'hFEED_FACE_0BAD_F00D;
        @(negedge clk);
        chk("rw5_en",   64'(obs_en), 64'h0020);
        chk("rw5_data", obs_wdata[5], 64'h5555_0000_0000_5555);
        repeat (3) tick();

        // Reads in flight when reset arrives must never respond.
        rd(16'h0000, 9'h040, 1'b0);
        rd(16'h0002, 9'h041, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("flush_rsp_valid", 64'(mmio_rsp_valid), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        chk("rst_clears_wdata", obs_wdata[3], 64'h0);
        rd(16'h0004, 9'h1FF, 1'b1);
        repeat (4) tick();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cci_test_csr_mgr.md
CCI_TEST_CSR_MGR -- requirements
Module: cci_test_csr_mgr

Interface
REQ-001 The block SHALL have parameter CSR_BASE_WADDR, default 16'h0020, giving the 32-bit-word MMIO address of test CSR 0.
REQ-002 The block SHALL have parameter NUM_TEST_CSRS, default 16, taken from the shared package.
REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- mmio_wr_valid  in  1  host MMIO write this cycle.
- mmio_wr_addr  in  16  write address in 32-bit words.
- mmio_wr_len64  in  1  1 = 64-bit access.
- mmio_wr_data  in  64  write data.
- mmio_rd_valid  in  1  host MMIO read request this cycle.
- mmio_rd_addr  in  16  read address in 32-bit words.
- mmio_rd_tid  in  9  read transaction ID.
- mmio_rsp_valid  out  1  read response valid.
- mmio_rsp_tid  out  9  echoed transaction ID.
- mmio_rsp_data  out  64  read data.
- csrs  test_csrs.csr  --  manager end of the test CSR interface; reads afu_id and cpu_rd_csrs, drives cpu_wr_csrs.

Function
REQ-004 The block SHALL decode 64-bit reads at word addresses: 0x0 DFH = 64'h1000_0100_0000_0000; 0x2 afu_id[63:0]; 0x4 afu_id[127:64]; 0x6 and 0x8 zero.
REQ-005 The block SHALL map test CSR i to word address CSR_BASE_WADDR + 2*i for i in 0..NUM_TEST_CSRS-1.
REQ-006 Reads of any other address, including odd word addresses, SHALL return 64'h0 with a valid response; no read is dropped.
REQ-007 Read latency SHALL be exactly 2 cycles:
- request registered in cycle N;
- data muxed and registered in cycle N+1;
- mmio_rsp_valid high in cycle N+2 for one cycle, with the matching tid.
REQ-008 Reads on consecutive cycles SHALL be fully pipelined, with back-to-back responses in order and no stall.
REQ-009 A write with mmio_wr_len64=1 to test CSR i's address in cycle N SHALL drive cpu_wr_csrs[i].en=1 for cycle N+1 only, with cpu_wr_csrs[i].data equal to the written value.
REQ-010 cpu_wr_csrs[i].data SHALL hold its last written value until the next write to CSR i.
REQ-011 Writes with mmio_wr_len64=0, or to any address outside the test CSR range, SHALL be ignored with no en pulse.
REQ-012 A simultaneous read and write in the same cycle SHALL both be processed.
REQ-013 A read of a CSR index being written in the same cycle SHALL return the cpu_rd_csrs value sampled in cycle N+1; no write-to-read forwarding exists.
REQ-014 At most one en bit SHALL be high in any cycle.

Reset
REQ-015 While reset is high:
- mmio_rsp_valid = 0, mmio_rsp_tid = 0, mmio_rsp_data = 0;
- all cpu_wr_csrs[i].en = 0 and cpu_wr_csrs[i].data = 0.
REQ-016 Reset asserted while reads are in the pipeline SHALL flush them; no response for those reads is ever issued.
REQ-017 The first request accepted after reset deasserts SHALL obey REQ-007 timing.

Structure
REQ-018 NUM_TEST_CSRS, the DFH constant, the fixed header word addresses and the response struct type SHALL live in the shared test package.
REQ-019 The read pipeline SHALL be one sub-module, cci_test_csr_rd_pipe (request register, address decode/mux, response register); write decode stays in the top module.

Verification
REQ-020 After reset, read word 0x0, tid 0x05 -> two cycles later, rsp_valid=1, tid=0x05, data=64'h1000_0100_0000_0000.
REQ-021 With afu_id=128'h0123..CDEF, read 0x2 then 0x4 on consecutive cycles -> two back-to-back responses carrying the low and high halves, in order.
REQ-022 64-bit write 64'hDEAD_BEEF to word 0x0026 (CSR 3) -> cpu_wr_csrs[3].en pulses one cycle later with data 64'hDEAD_BEEF; all other en stay 0.
REQ-023 32-bit write to word 0x0020, and a 64-bit write to word 0x0100 -> no en pulse on any CSR.
REQ-024 Read word 0x0021 and word 0x0040 -> data 0 for both, responses still issued.
REQ-025 Issue 2 reads, assert reset the next cycle -> no rsp_valid on any cycle; a read issued after reset returns at +2 cycles.
